// File: rtl/mcpu_ctrl.sv
// Multicycle CPU control FSM: decodes OPcode/Fun and sequences fetch, decode,
// execute, memory and writeback, driving the ALU, operand muxes and strobes.
module mcpu_ctrl #(
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [5:0]      OPcode,
  input  logic [5:0]      Fun,
  input  logic            zero,
  input  logic            MIO_ready,
  output logic [2:0]      ALU_Ctr,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic            ext_zero,
  output logic            IorD,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            RegWrite,
  output logic            RegDst,
  output logic            MemtoReg,
  output logic [1:0]      PCSource,
  output logic            PC_en,
  output logic [ST_W-1:0] state
);

  typedef enum logic [ST_W-1:0] {
    IF_S       = 4'd0,
    ID_S       = 4'd1,
    MEM_ADDR_S = 4'd2,
    MEM_RD_S   = 4'd3,
    LW_WB_S    = 4'd4,
    MEM_WR_S   = 4'd5,
    R_EX_S     = 4'd6,
    R_WB_S     = 4'd7,
    BEQ_S      = 4'd8,
    J_S        = 4'd9,
    I_EX_S     = 4'd10,
    I_WB_S     = 4'd11,
    BNE_S      = 4'd12
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] r_dec_s;
  logic [3:0] i_dec_s;

  // R-type function decode: {valid, ALU_Ctr}; unknown Fun falls back to ADD, invalid
  function automatic logic [3:0] r_decode(input logic [5:0] f);
    case (f)
      6'b100000: r_decode = {1'b1, 3'b010};
      6'b100010: r_decode = {1'b1, 3'b110};
      6'b100100: r_decode = {1'b1, 3'b000};
      6'b100101: r_decode = {1'b1, 3'b001};
      6'b100110: r_decode = {1'b1, 3'b011};
      6'b100111: r_decode = {1'b1, 3'b101};
      6'b101010: r_decode = {1'b1, 3'b111};
      default:   r_decode = {1'b0, 3'b010};
    endcase
  endfunction

  // Immediate-op decode: {ext_zero, ALU_Ctr}; logical immediates are zero-extended
  function automatic logic [3:0] i_decode(input logic [5:0] op);
    case (op)
      6'b001000: i_decode = {1'b0, 3'b010};
      6'b001100: i_decode = {1'b1, 3'b000};
      6'b001101: i_decode = {1'b1, 3'b001};
      6'b001110: i_decode = {1'b1, 3'b011};
      6'b001010: i_decode = {1'b0, 3'b111};
      default:   i_decode = {1'b0, 3'b010};
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IF_S;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore output decode; everything is forced low while in reset
  always_comb begin
    state_d  = state_q;
    ALU_Ctr  = 3'b000;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ext_zero = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    PCSource = 2'b00;
    PC_en    = 1'b0;
    r_dec_s  = r_decode(Fun);
    i_dec_s  = i_decode(OPcode);
    if (rst_n) begin
      case (state_q)
        IF_S: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          ALU_Ctr = 3'b010;
          IRWrite = MIO_ready;
          PC_en   = MIO_ready;
          if (MIO_ready) state_d = ID_S;
          else           state_d = IF_S;
        end
        ID_S: begin
          ALUSrcB = 2'b11;
          ALU_Ctr = 3'b010;
          case (OPcode)
            6'b000000:            state_d = R_EX_S;
            6'b100011, 6'b101011: state_d = MEM_ADDR_S;
            6'b000100:            state_d = BEQ_S;
            6'b000101:            state_d = BNE_S;
            6'b000010:            state_d = J_S;
            6'b001000, 6'b001100, 6'b001101,
            6'b001110, 6'b001010: state_d = I_EX_S;
            default:              state_d = IF_S;
          endcase
        end
        MEM_ADDR_S: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALU_Ctr = 3'b010;
          if (OPcode == 6'b100011)      state_d = MEM_RD_S;
          else if (OPcode == 6'b101011) state_d = MEM_WR_S;
          else                          state_d = IF_S;
        end
        MEM_RD_S: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          if (MIO_ready) state_d = LW_WB_S;
          else           state_d = MEM_RD_S;
        end
        LW_WB_S: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
          state_d  = IF_S;
        end
        MEM_WR_S: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          if (MIO_ready) state_d = IF_S;
          else           state_d = MEM_WR_S;
        end
        R_EX_S: begin
          ALUSrcA = 1'b1;
          ALU_Ctr = r_dec_s[2:0];
          if (r_dec_s[3]) state_d = R_WB_S;
          else            state_d = IF_S;
        end
        R_WB_S: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
          state_d  = IF_S;
        end
        BEQ_S, BNE_S: begin
          ALUSrcA  = 1'b1;
          ALU_Ctr  = 3'b110;
          PCSource = 2'b01;
          PC_en    = (state_q == BEQ_S) ? zero : ~zero;
          state_d  = IF_S;
        end
        J_S: begin
          PCSource = 2'b10;
          PC_en    = 1'b1;
          state_d  = IF_S;
        end
        I_EX_S: begin
          ALUSrcA  = 1'b1;
          ALUSrcB  = 2'b10;
          ALU_Ctr  = i_dec_s[2:0];
          ext_zero = i_dec_s[3];
          state_d  = I_WB_S;
        end
        // ALU controls held over from I_EX so ALUOut does not move during writeback
        I_WB_S: begin
          RegWrite = 1'b1;
          ALU_Ctr  = i_dec_s[2:0];
          ext_zero = i_dec_s[3];
          state_d  = IF_S;
        end
        default: state_d = IF_S;
      endcase
    end else begin
      state_d = IF_S;
    end
  end

  assign state = state_q;

endmodule

// File: doc/mcpu_ctrl.md
Name: mcpu_ctrl

Overview:
- Multicycle control FSM that sits directly upstream of the 32-bit ALU in the multicycle CPU.
- Decodes OPcode/Fun from the instruction register and sequences the IF/ID/EX/MEM/WB steps.
- Drives the ALU's 3-bit ALU_Ctr, the operand-select muxes, memory strobes, register-file write enable and PC update enable.
- Consumes the ALU's zero flag for branch resolution.

Parameters:
- ST_W, 4, width of state register, exported on the debug port.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- OPcode  in  6  instruction[31:26] from the IR.
- Fun  in  6  instruction[5:0] from the IR.
- zero  in  1  ALU zero flag, valid in the branch state.
- MIO_ready  in  1  memory access complete; sampled in IF, MEM_RD and MEM_WR.
- ALU_Ctr  out  3  000 AND, 001 OR, 010 ADD, 011 XOR, 100 NAND, 101 NOR, 110 SUB, 111 SLT.
- ALUSrcA  out  1  0 = PC, 1 = register A.
- ALUSrcB  out  2  00 = register B, 01 = constant 4, 10 = extended imm, 11 = sign-extended imm<<2.
- ext_zero  out  1  1 = zero-extend imm (andi/ori/xori), else sign-extend.
- IorD  out  1  0 = PC address, 1 = ALUOut address.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  load instruction register.
- RegWrite  out  1  register-file write enable.
- RegDst  out  1  0 = rt, 1 = rd.
- MemtoReg  out  1  0 = ALUOut, 1 = MDR.
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- PC_en  out  1  PC load enable.
- state  out  ST_W  current state, for debug display.

Behaviour:
- Reset: async on rst_n low → state = IF. All strobes are 0 while rst_n is low: MemRead, MemWrite, IRWrite, RegWrite, PC_en. Every other output is 0. Releasing reset starts a fetch on the next edge. Reset mid-instruction aborts it with no further writes.
- Outputs are Moore, decoded combinationally from state. Exception: PC_en in BEQ/BNE also depends on zero. Unlisted outputs are 0 in every state.
- IF (0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_Ctr=010.
  - IRWrite and PC_en are asserted only while MIO_ready=1 (PCSource=00).
  - Stay in IF until MIO_ready=1, then go to ID.
- ID (1): ALUSrcA=0, ALUSrcB=11, ALU_Ctr=010 (branch target into ALUOut). Next state by OPcode:
  - 000000 → R_EX.
  - 100011 or 101011 → MEM_ADDR.
  - 000100 → BEQ.
  - 000101 → BNE.
  - 000010 → J.
  - 001000, 001100, 001101, 001110, 001010 → I_EX.
  - Any other opcode → IF. This is the illegal-instruction case: no register or memory write.
- MEM_ADDR (2): ALUSrcA=1, ALUSrcB=10, ALU_Ctr=010. Next state: lw → MEM_RD, sw → MEM_WR.
- MEM_RD (3): MemRead=1, IorD=1. Hold until MIO_ready, then → LW_WB.
- LW_WB (4): RegWrite=1, RegDst=0, MemtoReg=1. → IF.
- MEM_WR (5): MemWrite=1, IorD=1. Hold until MIO_ready, then → IF.
- R_EX (6): ALUSrcA=1, ALUSrcB=00. ALU_Ctr by Fun:
  - 100000 → 010.
  - 100010 → 110.
  - 100100 → 000.
  - 100101 → 001.
  - 100110 → 011.
  - 100111 → 101.
  - 101010 → 111.
  - Any other Fun → ALU_Ctr=010 and the next state is IF (no writeback).
  - Otherwise → R_WB.
- R_WB (7): RegWrite=1, RegDst=1, MemtoReg=0. → IF.
- BEQ (8): ALUSrcA=1, ALUSrcB=00, ALU_Ctr=110, PCSource=01, PC_en=zero. → IF.
- BNE (12): same as BEQ but PC_en=~zero. → IF.
- J (9): PCSource=10, PC_en=1. → IF.
- I_EX (10): ALUSrcA=1, ALUSrcB=10. ALU_Ctr and ext_zero by OPcode:
  - addi → ALU_Ctr=010.
  - andi → ALU_Ctr=000, ext_zero=1.
  - ori → ALU_Ctr=001, ext_zero=1.
  - xori → ALU_Ctr=011, ext_zero=1.
  - slti → ALU_Ctr=111.
  - → I_WB.
- I_WB (11): RegWrite=1, RegDst=0, MemtoReg=0. → IF. ALU_Ctr and ext_zero keep their I_EX values so ALUOut stays stable.
- Unused state encodings (13–15) → IF on the next edge, with all strobes 0.
- Cycle counts with MIO_ready tied to 1:
  - R-type and I-type: 4.
  - lw: 5.
  - sw: 4.
  - beq, bne, j: 3.
  - Each cycle with MIO_ready=0 in IF, MEM_RD or MEM_WR adds one cycle.

Test Plan:
- Reset with rst_n=0 asserted mid-MEM_WR → state=0 and MemWrite=0 immediately, asynchronously. Release with MIO_ready=1 → IRWrite=1 and PC_en=1 on the first cycle.
- Instruction add (OPcode=0, Fun=100000), MIO_ready=1 → state sequence 0,1,6,7,0. ALU_Ctr=010 in state 6. RegWrite=1 and RegDst=1 only in state 7.
- lw (100011) with MIO_ready low for 2 cycles in MEM_RD → sequence 0,1,2,3,3,3,4,0. MemtoReg=1 and RegWrite=1 in state 4.
- beq with zero=1 → PC_en=1, PCSource=01 in state 8. Repeat with zero=0 → PC_en=0. bne with zero=0 → PC_en=1.
- ori (001101) → ext_zero=1 and ALU_Ctr=001 in states 10 and 11. slti → ALU_Ctr=111 and ext_zero=0.
- OPcode=111111 → sequence 0,1,0 with RegWrite=0 and MemWrite=0 throughout. R-type with Fun=000000 → sequence 0,1,6,0.
